// File: rtl/bottling_ctrl_gen2.sv
// Bottling line controller: conveyor/fill/seal sequencer with a two-level
// cork store (operator-loaded secondary buffer feeding the main buffer in
// batches) and bottle/dozen production counting.
module bottling_ctrl_gen2 #(
    parameter int unsigned MAIN_W   = 5,
    parameter int unsigned MAIN_MAX = 31,
    parameter int unsigned MAIN_MIN = 5,
    parameter int unsigned SEC_W    = 7,
    parameter int unsigned SEC_MAX  = 99,
    parameter int unsigned BATCH    = 20,
    parameter int unsigned DOZEN    = 12,
    parameter int unsigned DOZ_W    = 4,
    parameter int unsigned DOZ_MAX  = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_stop,
    input  logic             pg,
    input  logic             ch,
    input  logic             cq,
    input  logic             op_valid,
    input  logic [SEC_W-1:0] op_qty,
    output logic             op_ready,
    output logic             op_reject,
    output logic             m,
    output logic             ev,
    output logic             ve,
    output logic             al,
    output logic [1:0]       state,
    output logic [MAIN_W-1:0] main_cnt,
    output logic [SEC_W-1:0] sec_cnt,
    output logic [DOZ_W-1:0] dozen_cnt,
    output logic             dozen_wrap,
    output logic             xfer_busy
);
    localparam int unsigned UNIT_W = $clog2(DOZEN);
    localparam int unsigned REM_W  = $clog2(BATCH + 1);

    localparam logic [MAIN_W-1:0] MAIN_MIN_V = MAIN_W'(MAIN_MIN);
    localparam logic [MAIN_W-1:0] MAIN_MAX_V = MAIN_W'(MAIN_MAX);
    localparam logic [SEC_W-1:0]  BATCH_S    = SEC_W'(BATCH);
    localparam logic [SEC_W:0]    SEC_MAX_V  = (SEC_W + 1)'(SEC_MAX);
    localparam logic [UNIT_W-1:0] UNIT_LAST  = UNIT_W'(DOZEN - 1);
    localparam logic [DOZ_W-1:0]  DOZ_LAST   = DOZ_W'(DOZ_MAX - 1);
    localparam logic [REM_W-1:0]  BATCH_R    = REM_W'(BATCH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        FILL = 2'b10,
        SEAL = 2'b11
    } line_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } xfer_t;

    line_t             line_q;
    xfer_t             xfer_q;
    logic [MAIN_W-1:0] main_q, main_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [UNIT_W-1:0] unit_q;
    logic [DOZ_W-1:0]  doz_q;
    logic [REM_W-1:0]  rem_q;
    logic              cq_q;
    logic              rej_q, rej_d;
    logic              wrap_q;

    logic              seal_ok;
    logic              xfer_start;
    logic              xfer_step;
    logic              op_take;
    logic              op_fits;
    logic [SEC_W:0]    op_sum;

    // Event decode and next values for the two buffers, which have several writers.
    always_comb begin
        // A seal counts only on a fresh cq rise with a cork available; a rise
        // seen while the main buffer is empty is consumed and not remembered.
        seal_ok    = start_stop && (line_q == SEAL) && cq && !cq_q && (main_q != '0);
        xfer_start = (xfer_q == T_IDLE) && (main_q < MAIN_MIN_V) &&
                     (sec_q >= BATCH_S) && (line_q != SEAL);
        // The seal's decrement owns main_cnt that cycle, so the transfer waits.
        xfer_step  = (xfer_q == T_RUN) && !seal_ok && (main_q < MAIN_MAX_V) &&
                     (sec_q != '0);
        op_ready   = (xfer_q == T_IDLE) && !xfer_start;
        op_take    = op_valid && op_ready;
        op_sum     = {1'b0, sec_q} + {1'b0, op_qty};
        op_fits    = (op_sum <= SEC_MAX_V);

        main_d = main_q;
        if (seal_ok) begin
            main_d = main_q - MAIN_W'(1);
        end else if (xfer_step) begin
            main_d = main_q + MAIN_W'(1);
        end

        sec_d = sec_q;
        if (xfer_step) begin
            sec_d = sec_q - SEC_W'(1);
        end else if (op_take && op_fits) begin
            sec_d = op_sum[SEC_W-1:0];
        end

        rej_d = op_take && !op_fits;
    end

    // Line sequencer: conveyor, fill and seal stations.
    always_ff @(posedge clk) begin
        if (!clr) begin
            line_q <= IDLE;
        end else if (!start_stop) begin
            line_q <= IDLE;
        end else begin
            case (line_q)
                IDLE:    if (!al)     line_q <= MOVE;
                MOVE:    if (pg)      line_q <= FILL;
                FILL:    if (ch)      line_q <= SEAL;
                SEAL:    if (seal_ok) line_q <= MOVE;
                default:              line_q <= IDLE;
            endcase
        end
    end

    // Bottle and dozen counting with a one-cycle wrap pulse.
    always_ff @(posedge clk) begin
        if (!clr) begin
            unit_q <= '0;
            doz_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (!start_stop) begin
                unit_q <= '0;
                doz_q  <= '0;
            end else if (seal_ok) begin
                if (unit_q == UNIT_LAST) begin
                    unit_q <= '0;
                    if (doz_q == DOZ_LAST) begin
                        doz_q  <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        doz_q <= doz_q + DOZ_W'(1);
                    end
                end else begin
                    unit_q <= unit_q + UNIT_W'(1);
                end
            end
        end
    end

    // Batch transfer from secondary to main buffer.
    always_ff @(posedge clk) begin
        if (!clr) begin
            xfer_q <= T_IDLE;
            rem_q  <= '0;
        end else begin
            case (xfer_q)
                T_IDLE: begin
                    if (xfer_start) begin
                        xfer_q <= T_RUN;
                        rem_q  <= BATCH_R;
                    end
                end
                T_RUN: begin
                    if (xfer_step) begin
                        rem_q <= rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) begin
                            xfer_q <= T_IDLE;
                        end
                    end
                end
                default: xfer_q <= T_IDLE;
            endcase
        end
    end

    // Buffer levels, reject pulse and cq history.
    always_ff @(posedge clk) begin
        if (!clr) begin
            main_q <= '0;
            sec_q  <= '0;
            rej_q  <= 1'b0;
            cq_q   <= 1'b0;
        end else begin
            main_q <= main_d;
            sec_q  <= sec_d;
            rej_q  <= rej_d;
            cq_q   <= cq;
        end
    end

    assign state      = line_q;
    assign m          = (line_q == MOVE);
    assign ev         = (line_q == FILL);
    assign ve         = (line_q == SEAL);
    assign al         = (main_q == '0);
    assign main_cnt   = main_q;
    assign sec_cnt    = sec_q;
    assign dozen_cnt  = doz_q;
    assign dozen_wrap = wrap_q;
    assign op_reject  = rej_q;
    assign xfer_busy  = (xfer_q == T_RUN);

endmodule

// File: tb/tb_bottling_ctrl_gen2.sv
// Self-checking bench for bottling_ctrl_gen2: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural reference.
module tb_bottling_ctrl_gen2;
    localparam int MAIN_MAX = 31;
    localparam int MAIN_MIN = 5;
    localparam int SEC_MAX  = 99;
    localparam int BATCH    = 20;
    localparam int DOZEN    = 12;
    localparam int DOZ_MAX  = 10;

    logic       clk = 1'b0;
    logic       clr, start_stop, pg, ch, cq, op_valid;
    logic [6:0] op_qty;
    logic       op_ready, op_reject, m, ev, ve, al, dozen_wrap, xfer_busy;
    logic [1:0] state;
    logic [4:0] main_cnt;
    logic [6:0] sec_cnt;
    logic [3:0] dozen_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: line phase 0..3 = idle/move/fill/seal, buffer levels,
    // bottles in the current dozen, dozens, corks left in the current batch.
    int r_phase, r_main, r_sec, r_units, r_doz, r_left;
    bit r_busy, r_rej, r_wrap, r_prev_cq;

    bottling_ctrl_gen2 #(
        .MAIN_W(5), .MAIN_MAX(31), .MAIN_MIN(5), .SEC_W(7), .SEC_MAX(99),
        .BATCH(20), .DOZEN(12), .DOZ_W(4), .DOZ_MAX(10)
    ) dut (
        .clk(clk), .clr(clr), .start_stop(start_stop), .pg(pg), .ch(ch), .cq(cq),
        .op_valid(op_valid), .op_qty(op_qty), .op_ready(op_ready), .op_reject(op_reject),
        .m(m), .ev(ev), .ve(ve), .al(al), .state(state), .main_cnt(main_cnt),
        .sec_cnt(sec_cnt), .dozen_cnt(dozen_cnt), .dozen_wrap(dozen_wrap),
        .xfer_busy(xfer_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        int  o_main, o_sec;
        bit  seal, start, ready, step;
        if (!clr) begin
            r_phase = 0; r_main = 0; r_sec = 0; r_units = 0; r_doz = 0; r_left = 0;
            r_busy = 0; r_rej = 0; r_wrap = 0; r_prev_cq = 0;
            return;
        end
        o_main = r_main;
        o_sec  = r_sec;
        seal   = (r_phase == 3) && start_stop && cq && !r_prev_cq && (o_main > 0);
        start  = !r_busy && (o_main < MAIN_MIN) && (o_sec >= BATCH) && (r_phase != 3);
        ready  = !r_busy && !start;
        step   = r_busy && !seal && (o_main < MAIN_MAX);
        r_wrap = 0;
        if (!start_stop) begin
            r_phase = 0; r_units = 0; r_doz = 0;
        end else begin
            case (r_phase)
                0:       if (o_main != 0) r_phase = 1;
                1:       if (pg) r_phase = 2;
                2:       if (ch) r_phase = 3;
                default: if (seal) r_phase = 1;
            endcase
            if (seal) begin
                r_main = o_main - 1;
                r_units++;
                if (r_units == DOZEN) begin
                    r_units = 0;
                    r_doz++;
                    if (r_doz == DOZ_MAX) begin
                        r_doz  = 0;
                        r_wrap = 1;
                    end
                end
            end
        end
        if (start) begin
            r_busy = 1;
            r_left = BATCH;
        end else if (step) begin
            r_sec--; r_main++; r_left--;
            if (r_left == 0) r_busy = 0;
        end
        r_rej = 0;
        if (op_valid && ready) begin
            if (o_sec + int'(op_qty) <= SEC_MAX) r_sec = o_sec + int'(op_qty);
            else r_rej = 1;
        end
        r_prev_cq = cq;
    endtask

    task automatic compare_all();
        check("state", state, r_phase);
        check("m", m, r_phase == 1);
        check("ev", ev, r_phase == 2);
        check("ve", ve, r_phase == 3);
        check("al", al, r_main == 0);
        check("main_cnt", main_cnt, r_main);
        check("sec_cnt", sec_cnt, r_sec);
        check("dozen_cnt", dozen_cnt, r_doz);
        check("dozen_wrap", dozen_wrap, r_wrap);
        check("xfer_busy", xfer_busy, r_busy);
        check("op_reject", op_reject, r_rej);
        check("op_ready", op_ready,
              !r_busy && !((r_main < MAIN_MIN) && (r_sec >= BATCH) && (r_phase != 3)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic bottle();
        pg = 1; tick(); pg = 0;
        ch = 1; tick(); ch = 0;
        cq = 1; tick();
        cq = 0; tick();
    endtask

    task automatic load(input int qty);
        op_valid = 1; op_qty = 7'(qty); tick();
        op_valid = 0;
    endtask

    initial begin
        int busy_cycles;
        int main_before;

        clr = 0; start_stop = 0; pg = 0; ch = 0; cq = 0; op_valid = 0; op_qty = '0;

        // Reset state
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_main", main_cnt, 0);
        check("rst_sec", sec_cnt, 0);
        check("rst_al", al, 1);
        check("rst_busy", xfer_busy, 0);
        check("rst_mevve", {m, ev, ve}, 0);

        // Operator load then automatic batch transfer
        clr = 1;
        load(40);
        check("load40_sec", sec_cnt, 40);
        busy_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (xfer_busy === 1'b1) busy_cycles++;
        end
        check("xfer_len", busy_cycles, 20);
        check("xfer_main", main_cnt, 20);
        check("xfer_sec", sec_cnt, 20);
        check("xfer_al", al, 0);

        // Capacity limit on operator load
        load(70);
        check("load70_sec", sec_cnt, 90);
        load(10);
        check("over_reject", op_reject, 1);
        check("over_sec", sec_cnt, 90);
        tick();
        check("reject_pulse_end", op_reject, 0);
        load(9);
        check("fill_to_max", sec_cnt, 99);
        load(0);
        check("zero_qty", sec_cnt, 99);

        // One full bottle cycle
        start_stop = 1; tick();
        check("seq_move", state, 1);
        main_before = int'(main_cnt);
        pg = 1; tick(); pg = 0;
        check("seq_fill", state, 2);
        ch = 1; tick(); ch = 0;
        check("seq_seal", state, 3);
        cq = 1; tick();
        check("seq_back_move", state, 1);
        check("seal_dec", main_cnt, main_before - 1);
        cq = 0; tick();
        for (int i = 0; i < 11; i++) bottle();
        check("one_dozen", dozen_cnt, 1);

        // Stop in the middle of a fill
        pg = 1; tick(); pg = 0;
        check("stop_in_fill", state, 2);
        start_stop = 0; tick();
        check("stop_idle", state, 0);
        check("stop_dozen", dozen_cnt, 0);
        start_stop = 1; tick();

        // Run to 9 dozens + 11 bottles, then the wrapping seal
        for (int i = 0; i < 400 && !(r_doz == 9 && r_units == 11); i++) begin
            if (!r_busy && r_sec < 40) load(50);
            bottle();
        end
        check("pre_wrap_dozen", dozen_cnt, 9);
        pg = 1; tick(); pg = 0;
        ch = 1; tick(); ch = 0;
        cq = 1; tick();
        check("wrap_dozen", dozen_cnt, 0);
        check("wrap_pulse", dozen_wrap, 1);
        cq = 0; tick();
        check("wrap_pulse_end", dozen_wrap, 0);

        // Empty main buffer at the sealer
        clr = 0; start_stop = 0; tick();
        clr = 1;
        load(20);
        for (int i = 0; i < 22; i++) tick();
        start_stop = 1; tick();
        for (int i = 0; i < 20; i++) bottle();
        check("drained_main", main_cnt, 0);
        pg = 1; tick(); pg = 0;
        load(20);
        ch = 1; tick(); ch = 0;
        check("empty_seal_state", state, 3);
        check("empty_seal_al", al, 1);
        check("empty_seal_busy", xfer_busy, 1);
        cq = 1; tick();
        check("ignored_edge", state, 3);
        cq = 0; tick();
        cq = 1; tick();
        check("refilled_edge", state, 1);
        cq = 0;

        // Reset during a transfer
        check("mid_xfer", xfer_busy, 1);
        clr = 0; tick();
        check("abort_busy", xfer_busy, 0);
        check("abort_main", main_cnt, 0);
        check("abort_sec", sec_cnt, 0);
        check("abort_state", state, 0);
        clr = 1; tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            clr        = ($urandom_range(0, 299) != 0);
            start_stop = ($urandom_range(0, 39) != 0);
            pg         = 1'($urandom_range(0, 1));
            ch         = 1'($urandom_range(0, 1));
            cq         = 1'($urandom_range(0, 1));
            op_valid   = ($urandom_range(0, 3) == 0);
            op_qty     = 7'($urandom_range(0, 60));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bottling_ctrl_gen2.md
BOTTLING_CTRL_GEN2 -- requirements
Module: bottling_ctrl_gen2

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  MAIN_W 5, main cork buffer width;
  MAIN_MAX 31, main buffer capacity;
  MAIN_MIN 5, refill threshold;
  SEC_W 7, secondary buffer width;
  SEC_MAX 99, secondary capacity;
  BATCH 20, corks per transfer;
  DOZEN 12, bottles per dozen;
  DOZ_W 4, dozen counter width;
  DOZ_MAX 10, dozen wrap value.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low. Ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock;
  clr  in  1  synchronous active-low reset;
  start_stop  in  1  line run enable, level;
  pg  in  1  bottle present at station;
  ch  in  1  bottle full sensor;
  cq  in  1  seal-complete sensor, level;
  op_valid  in  1  operator load request;
  op_qty  in  SEC_W  corks offered;
  op_ready  out  1  load may be accepted;
  op_reject  out  1  one-cycle pulse, load refused;
  m  out  1  conveyor motor;
  ev  out  1  fill valve;
  ve  out  1  sealer;
  al  out  1  cork-absence alarm;
  state  out  2  FSM state code;
  main_cnt  out  MAIN_W  main buffer level;
  sec_cnt  out  SEC_W  secondary buffer level;
  dozen_cnt  out  DOZ_W  dozens completed;
  dozen_wrap  out  1  one-cycle pulse at dozen wrap;
  xfer_busy  out  1  transfer in progress.
REQ-003 All inputs SHALL be treated as synchronous to clk; debouncing is outside this block.

Function
REQ-010 Line FSM states SHALL be IDLE=00, MOVE=01, FILL=10, SEAL=11, driven on state.
REQ-011 Outputs per state SHALL be: m=1 only in MOVE; ev=1 only in FILL; ve=1 only in SEAL.
REQ-012 Transitions SHALL be:
  IDLE->MOVE when start_stop=1 and al=0;
  MOVE->FILL when pg=1;
  FILL->SEAL when ch=1;
  SEAL->MOVE on the first cycle cq is 1 after being 0 (rising edge) with main_cnt>0.
REQ-013 start_stop=0 SHALL force IDLE at the next edge from any state and clear the bottle-unit counter and dozen_cnt.
REQ-014 al SHALL equal (main_cnt==0), combinationally. A cq rising edge in SEAL with main_cnt==0 SHALL be ignored; the FSM stays in SEAL until refilled and a new edge occurs.
REQ-015 An accepted seal (REQ-012) SHALL decrement main_cnt by 1 and increment the bottle-unit counter in the same edge.
REQ-016 The unit counter SHALL run 0..DOZEN-1. At DOZEN-1 plus one seal, it SHALL wrap to 0 and increment dozen_cnt.
REQ-017 When dozen_cnt reaches DOZ_MAX, it SHALL instead load 0 and pulse dozen_wrap for 1 cycle.
REQ-020 Transfer FSM states SHALL be T_IDLE and T_RUN, with an internal remaining-count register.
REQ-021 In T_IDLE, if main_cnt<MAIN_MIN and sec_cnt>=BATCH and state!=SEAL, the FSM SHALL enter T_RUN with remaining=BATCH.
REQ-022 Each T_RUN cycle SHALL do sec_cnt-1, main_cnt+1, remaining-1, except cycles where REQ-015 decrements main_cnt, which stall the transfer.
REQ-023 When remaining reaches 0 the FSM SHALL return to T_IDLE. xfer_busy=1 exactly while in T_RUN.
REQ-024 Parameter constraint: MAIN_MIN-1+BATCH<=MAIN_MAX. main_cnt SHALL never exceed MAIN_MAX; an increment that would exceed it stalls the transfer.
REQ-030 op_ready SHALL be 1 only when the transfer FSM is in T_IDLE and no transfer start (REQ-021) fires that cycle. Transfer start has priority over operator load.
REQ-031 On op_valid=1 and op_ready=1:
  if sec_cnt+op_qty<=SEC_MAX (computed SEC_W+1 bits wide), sec_cnt SHALL update to the sum at the next edge;
  otherwise sec_cnt is unchanged and op_reject pulses 1 cycle.
REQ-032 op_qty=0 SHALL be accepted with no change. op_valid held high SHALL be re-evaluated every cycle; the operator drops it after acceptance.
REQ-033 sec_cnt SHALL never wrap below 0 or above SEC_MAX.

Reset
REQ-040 clr=0 at an edge SHALL set:
  state=IDLE, T_IDLE;
  main_cnt=0, sec_cnt=0, unit counter=0, dozen_cnt=0, remaining=0;
  op_reject=0, dozen_wrap=0.
  Combinational outputs then give m=ev=ve=0, xfer_busy=0, al=1.
REQ-041 clr asserted mid-transfer or mid-seal SHALL abort the operation with no partial update after that edge.

Verification
REQ-050 After reset, op_valid with op_qty=40 -> sec_cnt=40 next cycle. Transfer then starts: xfer_busy=1 for 20 cycles, ending at main_cnt=20, sec_cnt=20, al=0.
REQ-051 sec_cnt=90, op_qty=10 -> op_reject pulse, sec_cnt stays 90. op_qty=9 -> sec_cnt=99.
REQ-052 start_stop=1, then pg, ch, cq edge -> state sequence 00,01,10,11,01 and main_cnt decremented by 1. 12 such cycles -> dozen_cnt=1.
REQ-053 Starting at 9 dozens and 11 units, one seal -> dozen_cnt=0 and dozen_wrap high for 1 cycle.
REQ-054 main_cnt=0 in SEAL with a cq edge -> stays SEAL, al=1. After the transfer refills and a new cq edge arrives -> MOVE.
REQ-055 start_stop=0 mid-FILL -> IDLE next edge and dozen_cnt=0. clr=0 during T_RUN -> all counters 0, xfer_busy=0.
